// File: rtl/adc_capture_buffer_pkg.sv
// adc_capture_buffer_pkg: shared state encoding, default sizes and word-select width helper
package adc_capture_buffer_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, ARMING = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} cap_state_e;
  localparam int CAP_DATA_WIDTH = 512;
  localparam int CAP_DEPTH_LOG2 = 10;
  localparam int CAP_RD_WIDTH = 32;
  function automatic int wsel_width(input int data_w, input int rd_w);
    return $clog2(data_w / rd_w);
  endfunction
endpackage

// File: rtl/adc_capture_buffer_if.sv
// adc_capture_buffer_if: sample stream (tdata/tvalid/tready); master drives beats, slave returns tready
interface adc_capture_buffer_if
  import adc_capture_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = CAP_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master (output tdata, tvalid, input tready);
  modport slave (input tdata, tvalid, output tready);
endinterface

// File: rtl/adc_capture_buffer_bram.sv
// adc_capture_buffer_bram: simple dual-port RAM; ports aclk, we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o registered
module adc_capture_buffer_bram
  import adc_capture_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = CAP_DATA_WIDTH,
  parameter int DEPTH_LOG2 = CAP_DEPTH_LOG2
) (
  input  logic                  aclk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge aclk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: triggered snapshot of a sample stream; ports aclk/aresetn, s_axis stream, arm/trig_in/pretrig_len control, state_o/done/trig_ptr status, rd_en/rd_addr -> rd_data/rd_valid readout
module adc_capture_buffer
  import adc_capture_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = CAP_DATA_WIDTH,
  parameter int DEPTH_LOG2 = CAP_DEPTH_LOG2,
  parameter int RD_WIDTH = CAP_RD_WIDTH,
  localparam int WSEL_W = wsel_width(DATA_WIDTH, RD_WIDTH)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  adc_capture_buffer_if.slave          s_axis,
  input  logic                         arm,
  input  logic                         trig_in,
  input  logic [DEPTH_LOG2-1:0]        pretrig_len,
  output logic [2:0]                   state_o,
  output logic                         done,
  output logic [DEPTH_LOG2-1:0]        trig_ptr,
  input  logic                         rd_en,
  input  logic [DEPTH_LOG2+WSEL_W-1:0] rd_addr,
  output logic [RD_WIDTH-1:0]          rd_data,
  output logic                         rd_valid
);
  cap_state_e state_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, pre_q, start_ptr_q, trig_ptr_q, rd_beat;
  logic [DEPTH_LOG2:0] cnt_q, cnt_inc, post_target, trig_cnt;
  logic tready_q, done_q, wr_en, rd_v_q, rd_valid_q;
  logic [DATA_WIDTH-1:0] bram_q;
  logic [WSEL_W-1:0] wsel_q;
  logic [RD_WIDTH-1:0] rd_data_q;
  assign wr_en = s_axis.tvalid && (state_q inside {ARMING, ARMED, POST});
  assign cnt_inc = cnt_q + (DEPTH_LOG2+1)'(wr_en);
  assign trig_cnt = (DEPTH_LOG2+1)'(wr_en);
  assign post_target = (DEPTH_LOG2+1)'(2**DEPTH_LOG2) - {1'b0, pre_q};
  assign rd_beat = start_ptr_q + rd_addr[DEPTH_LOG2+WSEL_W-1:WSEL_W];
  assign s_axis.tready = tready_q;
  assign state_o = state_q;
  assign done = done_q;
  assign trig_ptr = trig_ptr_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  adc_capture_buffer_bram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_bram (
    .aclk   (aclk),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(s_axis.tdata),
    .re_i   (rd_en),
    .raddr_i(rd_beat),
    .rdata_o(bram_q)
  );
  // cnt_q counts pre-trigger beats in ARMING and post-trigger beats (trigger beat included) in POST
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      pre_q <= '0;
      cnt_q <= '0;
      start_ptr_q <= '0;
      trig_ptr_q <= '0;
      done_q <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (arm) begin
        state_q <= pretrig_len == '0 ? ARMED : ARMING;
        pre_q <= pretrig_len;
        cnt_q <= '0;
        done_q <= 1'b0;
      end else begin
        case (state_q)
          ARMING: begin
            cnt_q <= cnt_inc;
            if (cnt_inc == {1'b0, pre_q}) state_q <= ARMED;
          end
          ARMED: if (trig_in) begin
            trig_ptr_q <= wr_ptr_q;
            start_ptr_q <= wr_ptr_q - pre_q;
            cnt_q <= trig_cnt;
            // a maximal pre-trigger window completes on the trigger beat itself
            state_q <= trig_cnt == post_target ? DONE : POST;
            done_q <= trig_cnt == post_target;
          end
          POST: begin
            cnt_q <= cnt_inc;
            if (cnt_inc == post_target) begin
              state_q <= DONE;
              done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_v_q <= 1'b0;
      wsel_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_v_q <= rd_en;
      wsel_q <= rd_addr[WSEL_W-1:0];
      rd_valid_q <= rd_v_q;
      if (rd_v_q) rd_data_q <= bram_q[wsel_q*RD_WIDTH +: RD_WIDTH];
    end
  end
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: randomized stream/trigger stimulus checked against a window-level reference model
module tb_adc_capture_buffer;
  import adc_capture_buffer_pkg::*;
  localparam int DW = 512, DL = 4, RW = 32, WS = 4, DEPTH = 1 << DL, WORDS = DEPTH << WS;
  logic aclk = 1'b0, aresetn = 1'b1, arm = 1'b0, trig_in = 1'b0, rd_en = 1'b0;
  logic [DL-1:0] pretrig_len = '0, trig_ptr;
  logic [DL+WS-1:0] rd_addr = '0;
  logic [2:0] state_o;
  logic done, rd_valid;
  logic [RW-1:0] rd_data;
  adc_capture_buffer_if #(.DATA_WIDTH(DW)) s_axis ();
  adc_capture_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .RD_WIDTH(RW)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s_axis), .arm(arm), .trig_in(trig_in),
    .pretrig_len(pretrig_len), .state_o(state_o), .done(done), .trig_ptr(trig_ptr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );
  always #5 aclk = ~aclk;
  int vectors = 0, miscompares = 0, beat_n = 0, phys = 0, pre_m = 0, since_arm = 0, post_n = 0, trig_phys = 0;
  bit active, triggered, done_m, done_rise, p1_v, p2_v, p1_d, p2_d;
  logic [RW-1:0] p1_w, p2_w;
  logic [DW-1:0] hist [$];
  logic [DW-1:0] win [DEPTH];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] beat_data(input int n);
    logic [DW-1:0] d;
    for (int k = 0; k < 32; k++) d[16*k +: 16] = 16'(32*n + k);
    return d;
  endfunction
  function automatic logic [2:0] exp_state();
    if (done_m) return DONE;
    if (!active) return IDLE;
    if (triggered) return POST;
    return since_arm >= pre_m ? ARMED : ARMING;
  endfunction
  // model: a capture keeps every beat accepted after the arm cycle; the window is the last DEPTH of them
  task automatic model_edge(input bit a, input bit t, input bit v, input bit r, input int ra, input int pl);
    bit wrote = v && active;
    int old = phys;
    done_rise = 1'b0;
    if (wrote) begin
      hist.push_back(beat_data(beat_n));
      phys = (phys + 1) % DEPTH;
    end
    if (v) beat_n++;
    p2_v = p1_v; p2_d = p1_d; p2_w = p1_w;
    p1_v = r; p1_d = done_m; p1_w = win[ra >> WS][(ra & 15)*RW +: RW];
    if (a) begin
      active = 1; done_m = 0; triggered = 0; pre_m = pl; since_arm = 0; post_n = 0;
      hist.delete();
    end else if (active) begin
      if (!triggered && t && since_arm >= pre_m) begin
        triggered = 1;
        trig_phys = old;
      end
      if (triggered) post_n += int'(wrote); else since_arm += int'(wrote);
      if (triggered && post_n == DEPTH - pre_m) begin
        active = 0; done_m = 1; done_rise = 1;
        for (int i = 0; i < DEPTH; i++) win[i] = hist[hist.size() - DEPTH + i];
      end
    end
  endtask
  task automatic cycle(input bit a, input bit t, input bit v, input bit r, input int ra, input int pl);
    int rm = ra & (WORDS - 1);
    int plv = a ? pl : int'($urandom_range(DEPTH - 1));
    arm = a; trig_in = t; rd_en = r; rd_addr = (DL+WS)'(rm); pretrig_len = DL'(plv);
    s_axis.tvalid = v; s_axis.tdata = beat_data(beat_n);
    @(posedge aclk);
    model_edge(a, t, v, r, rm, plv);
    @(negedge aclk);
    check("state", state_o, exp_state());
    check("done", done, done_m);
    check("tready", s_axis.tready, 1);
    check("rd_valid", rd_valid, p2_v);
    if (p2_v && p2_d) check("rd_data", rd_data, p2_w);
    if (done_rise) check("trig_ptr", trig_ptr, trig_phys);
    arm = 0; trig_in = 0; rd_en = 0;
  endtask
  task automatic do_reset();
    #2 aresetn = 1'b0;
    #1;
    check("rst_state", state_o, IDLE);
    check("rst_done", done, 0);
    check("rst_tready", s_axis.tready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_trig_ptr", trig_ptr, 0);
    active = 0; done_m = 0; triggered = 0; phys = 0; p1_v = 0; p2_v = 0;
    hist.delete();
    repeat (2) @(negedge aclk);
    check("rst_hold_state", state_o, IDLE);
    check("rst_hold_tready", s_axis.tready, 0);
    aresetn = 1'b1;
  endtask
  task automatic run_to_done(input string tag, input int vpct, input bit rnd);
    for (int k = 0; k < 600 && !done; k++)
      cycle(rnd && $urandom_range(79) == 0, rnd && $urandom_range(4) == 0,
            $urandom_range(99) < vpct, $urandom_range(2) == 0, int'($urandom), int'($urandom_range(DEPTH - 1)));
    check(tag, done, 1);
  endtask
  task automatic read_all();
    for (int a = 0; a < WORDS; a++) cycle(0, 0, $urandom_range(1), 1, a, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
  endtask
  task automatic read_expect(input string tag, input int addr, input logic [31:0] exp);
    cycle(0, 0, 1, 1, addr, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check(tag, rd_data, exp);
  endtask
  initial begin
    int dbeat = -1, tb_beat;
    s_axis.tvalid = 0;
    s_axis.tdata = '0;
    do_reset();
    // spec scenario 1: pre=4, arm before beat 0, trigger on beat 10
    cycle(1, 0, 0, 0, 0, 4);
    for (int i = 0; i < 40 && !done; i++) begin
      cycle(0, i == 10, 1, 0, 0, 0);
      if (done) dbeat = i;
    end
    check("t1_done_beat", dbeat, 21);
    check("t1_trig_ptr", trig_ptr, 10);
    read_expect("t1_word0", 0, {16'd193, 16'd192});
    read_expect("t1_word1", 1, {16'd195, 16'd194});
    read_expect("t1_last", WORDS - 1, {16'd703, 16'd702});
    read_all();
    // scenario 2: pre=0, trigger right after arm
    cycle(1, 0, 1, 0, 0, 0);
    tb_beat = beat_n;
    cycle(0, 1, 1, 0, 0, 0);
    run_to_done("t2_done", 100, 0);
    read_expect("t2_first", 0, {16'(32*tb_beat + 1), 16'(32*tb_beat)});
    read_all();
    // scenario 3: trigger during ARMING is ignored
    cycle(1, 0, 1, 0, 0, 8);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    check("t3_ignored", state_o, ARMING);
    repeat (5) cycle(0, 0, 1, 0, 0, 0);
    check("t3_armed", state_o, ARMED);
    cycle(0, 1, 1, 0, 0, 0);
    run_to_done("t3_done", 100, 0);
    read_all();
    // scenario 4: tvalid toggling through POST
    cycle(1, 0, 1, 0, 0, 5);
    repeat (6) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 60 && !done; k++) cycle(0, 0, k % 2, 0, 0, 0);
    check("t4_done", done, 1);
    read_all();
    // scenario 5: arm beats same-cycle trigger; arm during POST restarts
    cycle(1, 0, 1, 0, 0, 2);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 3);
    check("t5_rearm", state_o, ARMING);
    repeat (4) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 6);
    check("t5_done_low", done, 0);
    repeat (7) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    run_to_done("t5_done", 100, 0);
    read_all();
    // scenario 6: reset in the middle of POST
    cycle(1, 0, 1, 0, 0, 3);
    repeat (4) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, 0, 0, 0);
    do_reset();
    repeat (6) cycle(0, 0, 1, $urandom_range(1), int'($urandom), 0);
    // randomized captures
    for (int n = 0; n < 14; n++) begin
      cycle(1, 0, $urandom_range(1), 0, 0, int'($urandom_range(DEPTH - 1)));
      run_to_done("rand_done", 75, 1);
      read_all();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
